// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and execute-operand front end of the pipelined OTTER core.
// Latches decoded instruction state and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
// Detects load-use hazards and drives the ALU operands, store data and branch/jump targets.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   stall, flush                    external hold / branch-taken bubble request
//   id_*                            decoded instruction fields from the ID stage
//   mem_rd/mem_reg_write/mem_fwd_data   EX/MEM forward source
//   wb_rd/wb_reg_write/wb_data          MEM/WB forward source
//   alu_a, alu_b                    ALU operands (combinational)
//   alu_ctrl, ex_pc, ex_rd, ex_ctrl, ex_valid   registered stage state
//   ex_store_data, ex_br_target, ex_jalr_target combinational from stage regs + forwards
//   load_use_stall                  combinational; hold IF/ID this cycle
module id_ex_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RA_W-1:0] id_rs1_addr,
    input  logic [RA_W-1:0] id_rs2_addr,
    input  logic [RA_W-1:0] id_rd_addr,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_alu_ctrl,
    input  logic            id_a_sel,
    input  logic [1:0]      id_b_sel,
    input  logic [5:0]      id_ctrl,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      alu_ctrl,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_br_target,
    output logic [XLEN-1:0] ex_jalr_target,
    output logic [XLEN-1:0] ex_pc,
    output logic [RA_W-1:0] ex_rd,
    output logic [5:0]      ex_ctrl,
    output logic            ex_valid,
    output logic            load_use_stall
);

    // ctrl bit order: {reg_write, mem_read, mem_write, branch, jal, jalr}
    localparam int unsigned CTRL_MEM_READ = 4;

    // operand B select encodings
    localparam logic [1:0] BSEL_RS2   = 2'd0;
    localparam logic [1:0] BSEL_IMM   = 2'd1;
    localparam logic [1:0] BSEL_FOUR  = 2'd2;

    logic [RA_W-1:0] ex_rs1_addr;
    logic [RA_W-1:0] ex_rs2_addr;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic            ex_a_sel;
    logic [1:0]      ex_b_sel;

    logic            wb_ok;
    logic            mem_ok;
    logic            wb_hit_id_rs1;
    logic            wb_hit_id_rs2;
    logic            wb_hit_ex_rs1;
    logic            wb_hit_ex_rs2;
    logic            mem_hit_ex_rs1;
    logic            mem_hit_ex_rs2;
    logic            hazard;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Forward-source match terms; x0 never forwards
    always_comb begin
        wb_ok          = wb_reg_write && (wb_rd != '0);
        mem_ok         = mem_reg_write && (mem_rd != '0);
        wb_hit_id_rs1  = wb_ok && (wb_rd == id_rs1_addr);
        wb_hit_id_rs2  = wb_ok && (wb_rd == id_rs2_addr);
        wb_hit_ex_rs1  = wb_ok && (wb_rd == ex_rs1_addr);
        wb_hit_ex_rs2  = wb_ok && (wb_rd == ex_rs2_addr);
        mem_hit_ex_rs1 = mem_ok && (mem_rd == ex_rs1_addr);
        mem_hit_ex_rs2 = mem_ok && (mem_rd == ex_rs2_addr);
    end

    // Load-use detection; suppressed when stall or flush already governs the edge
    always_comb begin
        hazard = ex_valid && ex_ctrl[CTRL_MEM_READ] && (ex_rd != '0) && id_valid &&
                 ((id_uses_rs1 && (id_rs1_addr == ex_rd)) ||
                  (id_uses_rs2 && (id_rs2_addr == ex_rd)));
        load_use_stall = hazard && !stall && !flush;
    end

    // Stage register: flush > stall > load-use bubble > load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            alu_ctrl    <= '0;
            ex_pc       <= '0;
            ex_rd       <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_a_sel    <= 1'b0;
            ex_b_sel    <= '0;
        end else if (flush || load_use_stall) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (stall) begin
            // held operands must not miss a writeback that retires while frozen
            if (wb_hit_ex_rs1) begin
                ex_rs1_data <= wb_data;
            end
            if (wb_hit_ex_rs2) begin
                ex_rs2_data <= wb_data;
            end
        end else begin
            ex_valid    <= id_valid;
            ex_ctrl     <= id_valid ? id_ctrl : 6'b0;
            alu_ctrl    <= id_alu_ctrl;
            ex_pc       <= id_pc;
            ex_rd       <= id_rd_addr;
            ex_rs1_addr <= id_rs1_addr;
            ex_rs2_addr <= id_rs2_addr;
            // same-cycle WB bypass: regfile read does not yet see this write
            ex_rs1_data <= wb_hit_id_rs1 ? wb_data : id_rs1_data;
            ex_rs2_data <= wb_hit_id_rs2 ? wb_data : id_rs2_data;
            ex_imm      <= id_imm;
            ex_a_sel    <= id_a_sel;
            ex_b_sel    <= id_b_sel;
        end
    end

    // Operand forwarding; the younger EX/MEM result wins over MEM/WB
    always_comb begin
        fwd_rs1 = ex_rs1_data;
        fwd_rs2 = ex_rs2_data;
        if (mem_hit_ex_rs1) begin
            fwd_rs1 = mem_fwd_data;
        end else if (wb_hit_ex_rs1) begin
            fwd_rs1 = wb_data;
        end
        if (mem_hit_ex_rs2) begin
            fwd_rs2 = mem_fwd_data;
        end else if (wb_hit_ex_rs2) begin
            fwd_rs2 = wb_data;
        end
    end

    // ALU operands, store data and targets
    always_comb begin
        alu_a = ex_a_sel ? ex_pc : fwd_rs1;
        case (ex_b_sel)
            BSEL_RS2:  alu_b = fwd_rs2;
            BSEL_IMM:  alu_b = ex_imm;
            BSEL_FOUR: alu_b = XLEN'(4);
            default:   alu_b = '0;
        endcase
        ex_store_data  = fwd_rs2;
        ex_br_target   = ex_pc + ex_imm;
        ex_jalr_target = (fwd_rs1 + ex_imm) & ~XLEN'(1);
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [4:0]  id_rd_addr;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_alu_ctrl;
    logic        id_a_sel;
    logic [1:0]  id_b_sel;
    logic [5:0]  id_ctrl;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [31:0] mem_fwd_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_ctrl;
    logic [31:0] ex_store_data;
    logic [31:0] ex_br_target;
    logic [31:0] ex_jalr_target;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd;
    logic [5:0]  ex_ctrl;
    logic        ex_valid;
    logic        load_use_stall;

    int total = 0;
    int bad   = 0;

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_ctrl(id_alu_ctrl), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_ctrl(id_ctrl),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_fwd_data(mem_fwd_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .ex_store_data(ex_store_data), .ex_br_target(ex_br_target),
        .ex_jalr_target(ex_jalr_target), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .load_use_stall(load_use_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        mem_rd = '0; mem_reg_write = 1'b0; mem_fwd_data = '0;
        wb_rd = '0; wb_reg_write = 1'b0; wb_data = '0;
    endtask

    task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic [4:0] ac, input logic asel,
                            input logic [1:0] bsel, input logic [5:0] ctrl);
        id_valid = 1'b1; id_pc = pc;
        id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
        id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_alu_ctrl = ac; id_a_sel = asel; id_b_sel = bsel; id_ctrl = ctrl;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive_id(32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 6'd0);
        id_valid = 1'b0;
        clear_fwd();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("rst_valid", 32'(ex_valid), 32'h0);
        check("rst_ctrl", 32'(ex_ctrl), 32'h0);
        check("rst_alu_ctrl", 32'(alu_ctrl), 32'h0);
        check("rst_pc", ex_pc, 32'h0);
        check("rst_rd", 32'(ex_rd), 32'h0);

        // MEM/WB forwarding priority on rs1=x5
        drive_id(32'h100, 5'd5, 5'd6, 5'd3, 32'h33, 32'h44, 32'h10, 5'h0A, 1'b0, 2'd0, 6'b100000);
        tick();
        check("load_valid", 32'(ex_valid), 32'h1);
        check("load_pc", ex_pc, 32'h100);
        check("load_rd", 32'(ex_rd), 32'd3);
        check("load_alu_ctrl", 32'(alu_ctrl), 32'h0A);
        check("load_ctrl", 32'(ex_ctrl), 32'h20);
        check("alu_b_rs2", alu_b, 32'h44);
        mem_rd = 5'd5; mem_reg_write = 1'b1; mem_fwd_data = 32'h11;
        wb_rd = 5'd5; wb_reg_write = 1'b1; wb_data = 32'h22;
        #1 check("fwd_mem_wins", alu_a, 32'h11);
        mem_reg_write = 1'b0;
        #1 check("fwd_wb", alu_a, 32'h22);
        mem_rd = 5'd0; wb_rd = 5'd0;
        #1 check("fwd_rd_x0", alu_a, 32'h33);
        clear_fwd();

        // rs1=x0 never forwarded; const-4 operand B
        drive_id(32'h104, 5'd0, 5'd0, 5'd2, 32'h55, 32'h0, 32'h0, 5'd1, 1'b0, 2'd2, 6'b100000);
        tick();
        mem_rd = 5'd0; mem_reg_write = 1'b1; mem_fwd_data = 32'h99;
        wb_rd = 5'd0; wb_reg_write = 1'b1; wb_data = 32'h98;
        #1 check("x0_no_fwd", alu_a, 32'h55);
        check("alu_b_four", alu_b, 32'h4);
        clear_fwd();
        id_b_sel = 2'd3;
        tick();
        check("alu_b_reserved", alu_b, 32'h0);

        // Targets: branch wrap-around, a_sel=PC, b_sel=imm
        drive_id(32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h8, 5'd0, 1'b1, 2'd1, 6'b000100);
        tick();
        check("br_wrap", ex_br_target, 32'h4);
        check("alu_a_pc", alu_a, 32'hFFFFFFFC);
        check("alu_b_imm", alu_b, 32'h8);
        drive_id(32'h400, 5'd10, 5'd0, 5'd1, 32'h1001, 32'h0, 32'h0, 5'd0, 1'b0, 2'd1, 6'b100001);
        tick();
        check("jalr_bit0", ex_jalr_target, 32'h1000);
        check("jalr_ctrl", 32'(ex_ctrl), 32'h21);

        // Load-use: lw x7 in EX, add x1,x7,x2 in ID
        drive_id(32'h200, 5'd2, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd1, 6'b110000);
        tick();
        drive_id(32'h204, 5'd7, 5'd2, 5'd1, 32'hBAD, 32'h20, 32'h0, 5'd0, 1'b0, 2'd0, 6'b100000);
        #1 check("lu_detect", 32'(load_use_stall), 32'h1);
        tick();
        check("lu_bubble_valid", 32'(ex_valid), 32'h0);
        check("lu_bubble_ctrl", 32'(ex_ctrl), 32'h0);
        check("lu_cleared", 32'(load_use_stall), 32'h0);
        wb_rd = 5'd7; wb_reg_write = 1'b1; wb_data = 32'h77;
        tick();
        clear_fwd();
        #1;
        check("lu_reload_valid", 32'(ex_valid), 32'h1);
        check("lu_reload_rd", 32'(ex_rd), 32'd1);
        check("lu_wb_bypass", alu_a, 32'h77);
        check("lu_rs2", alu_b, 32'h20);

        // lw with rd=x0 never causes a hazard
        drive_id(32'h208, 5'd2, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd1, 6'b110000);
        tick();
        drive_id(32'h20C, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 6'b100000);
        #1 check("lu_rd_x0", 32'(load_use_stall), 32'h0);

        // Stall capture: store with rs2=x9 frozen, x9 written mid-stall
        drive_id(32'h300, 5'd3, 5'd9, 5'd0, 32'h0, 32'h1111, 32'h4, 5'd0, 1'b0, 2'd1, 6'b001000);
        tick();
        stall = 1'b1;
        drive_id(32'h304, 5'd4, 5'd5, 5'd6, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 6'b100000);
        tick();
        check("stall_hold_pc", ex_pc, 32'h300);
        wb_rd = 5'd9; wb_reg_write = 1'b1; wb_data = 32'hDEAD;
        tick();
        clear_fwd();
        #1 check("stall_wb_capture", ex_store_data, 32'hDEAD);
        tick();
        stall = 1'b0;
        #1;
        check("release_store", ex_store_data, 32'hDEAD);
        check("release_pc", ex_pc, 32'h300);
        check("release_ctrl", 32'(ex_ctrl), 32'h08);

        // Flush vs stall with a live load-use hazard
        drive_id(32'h500, 5'd2, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd1, 6'b110000);
        tick();
        drive_id(32'h504, 5'd7, 5'd2, 5'd1, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 6'b100000);
        stall = 1'b1;
        #1 check("lu_masked_stall", 32'(load_use_stall), 32'h0);
        flush = 1'b1;
        #1 check("lu_masked_flush", 32'(load_use_stall), 32'h0);
        tick();
        check("flush_valid", 32'(ex_valid), 32'h0);
        check("flush_ctrl", 32'(ex_ctrl), 32'h0);
        flush = 1'b0; stall = 1'b0;

        // Async reset mid-stall with a hazard pending
        drive_id(32'h600, 5'd2, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 5'd3, 1'b0, 2'd1, 6'b110000);
        tick();
        drive_id(32'h604, 5'd7, 5'd2, 5'd1, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 6'b100000);
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(ex_valid), 32'h0);
        check("async_rst_ctrl", 32'(ex_ctrl), 32'h0);
        check("async_rst_pc", ex_pc, 32'h0);
        check("async_rst_lu", 32'(load_use_stall), 32'h0);
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_load", ex_pc, 32'h604);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
